dft_bin_power_detector: RTL and testbench

//  Downstream stage of the DFT accumulator. On the accumulator's one-cycle done pulse it snapshots all
//  NUM_BINS complex bin sums and streams |A_k|^2 = re^2 + im^2 per bin, bin 0 first, over a

---
 rtl/dft_bin_power_detector.sv | 167 ++++++++++++++++
 tb/tb_dft_bin_power_detector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dft_bin_power_detector.sv
// Bin power detector: snapshots a frame of complex DFT bin sums and streams re^2+im^2 per bin
// through a two-stage pipeline with valid/ready backpressure, then reports the frame's peak bin.
//
// state | meaning
// IDLE  | waiting for a frame-done pulse
// RUN   | streaming bin powers from the snapshot
// PEAK  | one-cycle peak report; a new frame may be accepted here
module dft_bin_power_detector #(
  parameter int NUM_BINS    = 4,
  parameter int ACCUM_WIDTH = 32,
  localparam int IDX_WIDTH  = $clog2(NUM_BINS),
  localparam int PWR_WIDTH  = 2 * ACCUM_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_BINS*ACCUM_WIDTH-1:0] A_real_i,
  input  logic [NUM_BINS*ACCUM_WIDTH-1:0] A_imag_i,
  input  logic                            valid_i,
  output logic                            busy_o,
  output logic                            overrun_o,
  output logic [PWR_WIDTH-1:0]            pwr_o,
  output logic [IDX_WIDTH-1:0]            bin_idx_o,
  output logic                            pwr_valid_o,
  input  logic                            pwr_ready_i,
  output logic                            pwr_last_o,
  output logic                            peak_valid_o,
  output logic [IDX_WIDTH-1:0]            peak_idx_o,
  output logic [PWR_WIDTH-1:0]            peak_pwr_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEAK = 2'd2;
  localparam logic [IDX_WIDTH-1:0] LAST_BIN = IDX_WIDTH'(NUM_BINS - 1);

  logic [1:0] state_q, state_d;

  logic signed [ACCUM_WIDTH-1:0] snap_re_q [NUM_BINS];
  logic signed [ACCUM_WIDTH-1:0] snap_im_q [NUM_BINS];

  logic [IDX_WIDTH-1:0] cnt_q;
  logic                 issued_q;

  logic                 s1_valid_q;
  logic [PWR_WIDTH-1:0] s1_re2_q, s1_im2_q;
  logic [IDX_WIDTH-1:0] s1_idx_q;
  logic                 s1_last_q;

  logic                 pwr_valid_q;
  logic [PWR_WIDTH-1:0] pwr_q;
  logic [IDX_WIDTH-1:0] bin_idx_q;
  logic                 pwr_last_q;

  logic [PWR_WIDTH-1:0] trk_pwr_q, peak_pwr_q;
  logic [IDX_WIDTH-1:0] trk_idx_q, peak_idx_q;
  logic                 overrun_q;

  logic                        stall, accept, s1_load, hs, last_hs, pk_upd;
  logic signed [ACCUM_WIDTH-1:0] sel_re, sel_im;
  logic signed [PWR_WIDTH-1:0]   sq_re, sq_im;

  always_comb begin
    stall   = pwr_valid_q && !pwr_ready_i;
    accept  = valid_i && (state_q != S_RUN);
    s1_load = (state_q == S_RUN) && !issued_q && !stall;
    hs      = pwr_valid_q && pwr_ready_i;
    last_hs = hs && pwr_last_q;
    pk_upd  = pwr_q > trk_pwr_q;
    sel_re  = snap_re_q[cnt_q];
    sel_im  = snap_im_q[cnt_q];
    // Operands sign-extended to full width so the products are exact
    sq_re   = PWR_WIDTH'(sel_re) * PWR_WIDTH'(sel_re);
    sq_im   = PWR_WIDTH'(sel_im) * PWR_WIDTH'(sel_im);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_i) state_d = S_RUN;
      S_RUN:   if (last_hs) state_d = S_PEAK;
      S_PEAK:  state_d = valid_i ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < NUM_BINS; k++) begin
        snap_re_q[k] <= '0;
        snap_im_q[k] <= '0;
      end
      cnt_q       <= '0;
      issued_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_re2_q    <= '0;
      s1_im2_q    <= '0;
      s1_idx_q    <= '0;
      s1_last_q   <= 1'b0;
      pwr_valid_q <= 1'b0;
      pwr_q       <= '0;
      bin_idx_q   <= '0;
      pwr_last_q  <= 1'b0;
      trk_pwr_q   <= '0;
      trk_idx_q   <= '0;
      peak_pwr_q  <= '0;
      peak_idx_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= valid_i && (state_q == S_RUN);

      if (accept) begin
        for (int k = 0; k < NUM_BINS; k++) begin
          snap_re_q[k] <= A_real_i[k*ACCUM_WIDTH +: ACCUM_WIDTH];
          snap_im_q[k] <= A_imag_i[k*ACCUM_WIDTH +: ACCUM_WIDTH];
        end
        cnt_q     <= '0;
        issued_q  <= 1'b0;
        trk_pwr_q <= '0;
        trk_idx_q <= '0;
      end else begin
        if (s1_load) begin
          if (cnt_q == LAST_BIN) issued_q <= 1'b1;
          else                   cnt_q    <= cnt_q + IDX_WIDTH'(1);
        end
        // Strict compare: ties keep the earlier (lower) bin
        if (hs && pk_upd) begin
          trk_pwr_q <= pwr_q;
          trk_idx_q <= bin_idx_q;
        end
      end

      if (!stall) begin
        s1_valid_q <= s1_load;
        if (s1_load) begin
          s1_re2_q  <= $unsigned(sq_re);
          s1_im2_q  <= $unsigned(sq_im);
          s1_idx_q  <= cnt_q;
          s1_last_q <= (cnt_q == LAST_BIN);
        end
        pwr_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          pwr_q      <= s1_re2_q + s1_im2_q;
          bin_idx_q  <= s1_idx_q;
          pwr_last_q <= s1_last_q;
        end
      end

      if (last_hs) begin
        peak_pwr_q <= pk_upd ? pwr_q : trk_pwr_q;
        peak_idx_q <= pk_upd ? bin_idx_q : trk_idx_q;
      end
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign peak_valid_o = (state_q == S_PEAK);
  assign overrun_o    = overrun_q;
  assign pwr_o        = pwr_q;
  assign bin_idx_o    = bin_idx_q;
  assign pwr_valid_o  = pwr_valid_q;
  assign pwr_last_o   = pwr_last_q;
  assign peak_idx_o   = peak_idx_q;
  assign peak_pwr_o   = peak_pwr_q;

endmodule

// File: tb/tb_dft_bin_power_detector.sv
// Directed bench for dft_bin_power_detector (NUM_BINS=4, ACCUM_WIDTH=16) with hand-computed powers.
module tb_dft_bin_power_detector;
  localparam int NB = 4;
  localparam int W  = 16;
  localparam int PW = 32;
  localparam int IW = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NB*W-1:0] A_real_i, A_imag_i;
  logic            valid_i, pwr_ready_i;
  logic            busy_o, overrun_o, pwr_valid_o, pwr_last_o, peak_valid_o;
  logic [PW-1:0]   pwr_o, peak_pwr_o;
  logic [IW-1:0]   bin_idx_o, peak_idx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dft_bin_power_detector #(.NUM_BINS(NB), .ACCUM_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .A_real_i(A_real_i), .A_imag_i(A_imag_i),
    .valid_i(valid_i), .busy_o(busy_o), .overrun_o(overrun_o), .pwr_o(pwr_o),
    .bin_idx_o(bin_idx_o), .pwr_valid_o(pwr_valid_o), .pwr_ready_i(pwr_ready_i),
    .pwr_last_o(pwr_last_o), .peak_valid_o(peak_valid_o), .peak_idx_o(peak_idx_o),
    .peak_pwr_o(peak_pwr_o)
  );

  function automatic logic [NB*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[W-1:0], a2[W-1:0], a1[W-1:0], a0[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Sample mid-cycle, then advance to the start of the next cycle.
  task automatic cyc(input string tag, input logic eb, input logic eo, input logic ev,
                     input logic [PW-1:0] ep, input logic [IW-1:0] ei, input logic el,
                     input logic epk, input logic [IW-1:0] eki, input logic [PW-1:0] ekp);
    @(negedge clk_i);
    chk({tag, ".busy"}, 64'(busy_o), 64'(eb));
    chk({tag, ".overrun"}, 64'(overrun_o), 64'(eo));
    chk({tag, ".pwr_valid"}, 64'(pwr_valid_o), 64'(ev));
    chk({tag, ".peak_valid"}, 64'(peak_valid_o), 64'(epk));
    if (ev) begin
      chk({tag, ".pwr"}, 64'(pwr_o), 64'(ep));
      chk({tag, ".idx"}, 64'(bin_idx_o), 64'(ei));
      chk({tag, ".last"}, 64'(pwr_last_o), 64'(el));
    end
    if (epk) begin
      chk({tag, ".peak_idx"}, 64'(peak_idx_o), 64'(eki));
      chk({tag, ".peak_pwr"}, 64'(peak_pwr_o), 64'(ekp));
    end
    next_cycle();
  endtask

  task automatic run_basic(input string tag);
    A_real_i = pk(3, 0, -4, 1);
    A_imag_i = pk(4, 5, -3, 0);
    valid_i = 1'b1;
    pwr_ready_i = 1'b1;
    cyc({tag, ".c0"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    valid_i = 1'b0;
    cyc({tag, ".c1"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc({tag, ".c2"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc({tag, ".c3"}, 1, 0, 1, 25, 0, 0, 0, 0, 0);
    cyc({tag, ".c4"}, 1, 0, 1, 25, 1, 0, 0, 0, 0);
    cyc({tag, ".c5"}, 1, 0, 1, 25, 2, 0, 0, 0, 0);
    cyc({tag, ".c6"}, 1, 0, 1, 1, 3, 1, 0, 0, 0);
    cyc({tag, ".c7"}, 1, 0, 0, 0, 0, 0, 1, 0, 25);
    cyc({tag, ".c8"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    valid_i = 1'b0;
    pwr_ready_i = 1'b1;
    A_real_i = '0;
    A_imag_i = '0;
    next_cycle();
    next_cycle();
    chk("rst.busy", 64'(busy_o), 64'd0);
    chk("rst.overrun", 64'(overrun_o), 64'd0);
    chk("rst.pwr_valid", 64'(pwr_valid_o), 64'd0);
    chk("rst.pwr", 64'(pwr_o), 64'd0);
    chk("rst.idx", 64'(bin_idx_o), 64'd0);
    chk("rst.last", 64'(pwr_last_o), 64'd0);
    chk("rst.peak_valid", 64'(peak_valid_o), 64'd0);
    chk("rst.peak_idx", 64'(peak_idx_o), 64'd0);
    chk("rst.peak_pwr", 64'(peak_pwr_o), 64'd0);
    rst_i = 1'b0;
    next_cycle();

    // Basic frame
    run_basic("t1");

    // Extremes: (-32768)^2 * 2 = 2^31
    A_real_i = pk(0, 0, -32768, 0);
    A_imag_i = pk(0, 0, -32768, 0);
    valid_i = 1'b1;
    cyc("t2.c0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    valid_i = 1'b0;
    cyc("t2.c1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t2.c2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t2.c3", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("t2.c4", 1, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("t2.c5", 1, 0, 1, 32'd2147483648, 2, 0, 0, 0, 0);
    cyc("t2.c6", 1, 0, 1, 0, 3, 1, 0, 0, 0);
    cyc("t2.c7", 1, 0, 0, 0, 0, 0, 1, 2, 32'd2147483648);
    cyc("t2.c8", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Backpressure; powers 5,36,13,36 -> tie at 36 keeps bin 1
    A_real_i = pk(1, -6, 2, 6);
    A_imag_i = pk(2, 0, 3, 0);
    valid_i = 1'b1;
    cyc("t3.c0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    valid_i = 1'b0;
    cyc("t3.c1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t3.c2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    pwr_ready_i = 1'b0;
    cyc("t3.c3", 1, 0, 1, 5, 0, 0, 0, 0, 0);
    cyc("t3.c4", 1, 0, 1, 5, 0, 0, 0, 0, 0);
    cyc("t3.c5", 1, 0, 1, 5, 0, 0, 0, 0, 0);
    pwr_ready_i = 1'b1;
    cyc("t3.c6", 1, 0, 1, 5, 0, 0, 0, 0, 0);
    cyc("t3.c7", 1, 0, 1, 36, 1, 0, 0, 0, 0);
    cyc("t3.c8", 1, 0, 1, 13, 2, 0, 0, 0, 0);
    cyc("t3.c9", 1, 0, 1, 36, 3, 1, 0, 0, 0);
    cyc("t3.c10", 1, 0, 0, 0, 0, 0, 1, 1, 36);
    cyc("t3.c11", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Overrun in RUN, then back-to-back frame accepted in PEAK
    A_real_i = pk(3, 0, -4, 1);
    A_imag_i = pk(4, 5, -3, 0);
    valid_i = 1'b1;
    cyc("t4.c0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    valid_i = 1'b0;
    cyc("t4.c1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t4.c2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t4.c3", 1, 0, 1, 25, 0, 0, 0, 0, 0);
    A_real_i = pk(100, 100, 100, 100);
    A_imag_i = pk(100, 100, 100, 100);
    valid_i = 1'b1;
    cyc("t4.c4", 1, 0, 1, 25, 1, 0, 0, 0, 0);
    valid_i = 1'b0;
    cyc("t4.c5", 1, 1, 1, 25, 2, 0, 0, 0, 0);
    cyc("t4.c6", 1, 0, 1, 1, 3, 1, 0, 0, 0);
    A_real_i = pk(0, 0, 0, 7);
    A_imag_i = pk(0, 1, 0, 0);
    valid_i = 1'b1;
    cyc("t4.c7", 1, 0, 0, 0, 0, 0, 1, 0, 25);
    valid_i = 1'b0;
    cyc("t4.c8", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t4.c9", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t4.c10", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("t4.c11", 1, 0, 1, 1, 1, 0, 0, 0, 0);
    cyc("t4.c12", 1, 0, 1, 0, 2, 0, 0, 0, 0);
    cyc("t4.c13", 1, 0, 1, 49, 3, 1, 0, 0, 0);
    cyc("t4.c14", 1, 0, 0, 0, 0, 0, 1, 3, 49);
    cyc("t4.c15", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-frame
    A_real_i = pk(3, 0, -4, 1);
    A_imag_i = pk(4, 5, -3, 0);
    valid_i = 1'b1;
    cyc("t5.c0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    valid_i = 1'b0;
    cyc("t5.c1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t5.c2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t5.c3", 1, 0, 1, 25, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    cyc("t5.c4", 1, 0, 1, 25, 1, 0, 0, 0, 0);
    rst_i = 1'b0;
    chk("t5.c5.pwr", 64'(pwr_o), 64'd0);
    chk("t5.c5.idx", 64'(bin_idx_o), 64'd0);
    chk("t5.c5.last", 64'(pwr_last_o), 64'd0);
    chk("t5.c5.peak_idx", 64'(peak_idx_o), 64'd0);
    chk("t5.c5.peak_pwr", 64'(peak_pwr_o), 64'd0);
    cyc("t5.c5", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t5.c6", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t5.c7", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t5.c8", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_basic("t5b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
